// File: rtl/ask_mod_stream.sv
// M-ASK/OOK modulator: integer-divided square carrier gating a per-symbol amplitude,
// with symbols accepted over a valid/ready handshake and held for CYC_PER_SYM carrier periods.
module ask_mod_stream #(
    parameter int DIV         = 4,
    parameter int CYC_PER_SYM = 2,
    parameter int BITS        = 1,
    parameter int STEP        = 1,
    parameter int AW          = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [BITS-1:0] s_data,
    output logic [AW-1:0]   y,
    output logic            carrier,
    output logic            busy,
    output logic            sym_done
);

    localparam int CW = $clog2(DIV);
    localparam int SW = (CYC_PER_SYM > 1) ? $clog2(CYC_PER_SYM) : 1;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [SW-1:0]   sym_cnt, sym_cnt_n;
    logic [BITS-1:0] sym, sym_n;
    logic            carrier_n;
    logic [AW-1:0]   y_n;
    logic            last;
    logic            accept;

    assign last     = (state == ACTIVE) && (cnt == CW'(DIV - 1))
                      && (sym_cnt == SW'(CYC_PER_SYM - 1));
    assign s_ready  = rst && ((state == IDLE) || last);
    assign accept   = s_valid && s_ready;
    assign busy     = (state == ACTIVE);
    assign sym_done = last;

    always_comb begin
        state_n   = state;
        cnt_n     = '0;
        sym_cnt_n = '0;
        sym_n     = sym;
        if (accept) begin
            state_n = ACTIVE;
            sym_n   = s_data;
        end else if (state == ACTIVE) begin
            if (last) begin
                state_n = IDLE;
            end else if (cnt == CW'(DIV - 1)) begin
                sym_cnt_n = sym_cnt + SW'(1);
            end else begin
                cnt_n     = cnt + CW'(1);
                sym_cnt_n = sym_cnt;
            end
        end
        // Outputs are registered from the next-state values so y/carrier
        // reflect the new symbol right after the accepting edge.
        carrier_n = (state_n == ACTIVE) && (cnt_n < CW'(DIV / 2));
        y_n       = carrier_n ? (AW'(sym_n) * AW'(STEP)) : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            sym_cnt <= '0;
            sym     <= '0;
            carrier <= 1'b0;
            y       <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            sym_cnt <= sym_cnt_n;
            sym     <= sym_n;
            carrier <= carrier_n;
            y       <= y_n;
        end
    end

endmodule

// File: tb/tb_ask_mod_stream.sv
// Directed bench for ask_mod_stream: cycle table on a 4-ASK instance, reset sequence,
// and single-symbol runs on OOK and swept-divider instances.
module tb_ask_mod_stream;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // main 4-ASK instance
    logic       m_valid;
    logic [1:0] m_data;
    logic       m_ready, m_car, m_busy, m_done;
    logic [3:0] m_y;

    ask_mod_stream #(.DIV(4), .CYC_PER_SYM(2), .BITS(2), .STEP(5), .AW(4)) u_main (
        .clk(clk), .rst(rst), .s_valid(m_valid), .s_ready(m_ready), .s_data(m_data),
        .y(m_y), .carrier(m_car), .busy(m_busy), .sym_done(m_done)
    );

    // auxiliary instances: 0 = OOK defaults, 1 = DIV2/C1, 2 = DIV10/C3
    logic       av [3];
    logic [2:0] ad [3];
    logic       ar [3], ac [3], ab [3], adn [3];
    logic [3:0] ay [3];
    logic       y_ook;
    logic [3:0] y_d2, y_d10;

    ask_mod_stream u_ook (
        .clk(clk), .rst(rst), .s_valid(av[0]), .s_ready(ar[0]), .s_data(ad[0][0]),
        .y(y_ook), .carrier(ac[0]), .busy(ab[0]), .sym_done(adn[0])
    );
    ask_mod_stream #(.DIV(2), .CYC_PER_SYM(1), .BITS(2), .STEP(3), .AW(4)) u_d2 (
        .clk(clk), .rst(rst), .s_valid(av[1]), .s_ready(ar[1]), .s_data(ad[1][1:0]),
        .y(y_d2), .carrier(ac[1]), .busy(ab[1]), .sym_done(adn[1])
    );
    ask_mod_stream #(.DIV(10), .CYC_PER_SYM(3), .BITS(3), .STEP(2), .AW(4)) u_d10 (
        .clk(clk), .rst(rst), .s_valid(av[2]), .s_ready(ar[2]), .s_data(ad[2]),
        .y(y_d10), .carrier(ac[2]), .busy(ab[2]), .sym_done(adn[2])
    );

    always_comb begin
        ay[0] = {3'b000, y_ook};
        ay[1] = y_d2;
        ay[2] = y_d10;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       v;
        logic [1:0] d;
        logic [3:0] y;
        logic       car, busy, rdy, done;
    } vec_t;

    vec_t tbl[$];

    function automatic void push(logic v, logic [1:0] d, logic [3:0] y,
                                 logic car, logic busy, logic rdy, logic done);
        vec_t r;
        r.v = v; r.d = d; r.y = y; r.car = car; r.busy = busy; r.rdy = rdy; r.done = done;
        tbl.push_back(r);
    endfunction

    // Eight rows of one DIV=4, CYC=2 symbol; valid asserted from row von on.
    function automatic void sym8(logic [3:0] amp, int von, logic [1:0] dmid,
                                 logic vlast, logic [1:0] dlast);
        logic [7:0] pat;
        pat = 8'b00110011;
        for (int i = 0; i < 8; i++) begin
            if (i == 7)
                push(vlast, dlast, pat[i] ? amp : 4'd0, pat[i], 1'b1, 1'b1, 1'b1);
            else
                push(i >= von, (i >= von) ? dmid : 2'd0, pat[i] ? amp : 4'd0,
                     pat[i], 1'b1, 1'b0, 1'b0);
        end
    endfunction

    task automatic run_sym(input int idx, input int div, input int cyc,
                           input logic [2:0] k, input logic [3:0] amp);
        string nm;
        nm = $sformatf("aux%0d", idx);
        @(negedge clk);
        av[idx] = 1'b1;
        ad[idx] = k;
        #1;
        chk({nm, "_ready_idle"}, 32'(ar[idx]), 1);
        chk({nm, "_busy_idle"}, 32'(ab[idx]), 0);
        @(negedge clk);
        av[idx] = 1'b0;
        ad[idx] = 3'd0;
        for (int i = 0; i < div * cyc; i++) begin
            logic hi;
            hi = (i % div) < (div / 2);
            #1;
            chk({nm, "_y"}, 32'(ay[idx]), hi ? 32'(amp) : 0);
            chk({nm, "_carrier"}, 32'(ac[idx]), 32'(hi));
            chk({nm, "_busy"}, 32'(ab[idx]), 1);
            chk({nm, "_done"}, 32'(adn[idx]), (i == div * cyc - 1) ? 1 : 0);
            @(negedge clk);
        end
        #1;
        chk({nm, "_busy_after"}, 32'(ab[idx]), 0);
        chk({nm, "_y_after"}, 32'(ay[idx]), 0);
    endtask

    initial begin
        m_valid = 1'b0;
        m_data  = 2'd0;
        for (int i = 0; i < 3; i++) begin
            av[i] = 1'b0;
            ad[i] = 3'd0;
        end

        // single symbol k=3
        push(1, 2'd3, 0, 0, 0, 1, 0);
        sym8(4'd15, 8, 2'd0, 0, 2'd0);
        push(0, 2'd0, 0, 0, 0, 1, 0);
        // back-to-back 1,2,0 with valid held
        push(1, 2'd1, 0, 0, 0, 1, 0);
        sym8(4'd5, 0, 2'd2, 1, 2'd2);
        sym8(4'd10, 0, 2'd0, 1, 2'd0);
        sym8(4'd0, 8, 2'd0, 0, 2'd0);
        push(0, 2'd0, 0, 0, 0, 1, 0);
        // valid raised mid-symbol; data changes before the last cycle must be ignored
        push(1, 2'd1, 0, 0, 0, 1, 0);
        sym8(4'd5, 2, 2'd2, 1, 2'd3);
        sym8(4'd15, 8, 2'd0, 0, 2'd0);
        push(0, 2'd0, 0, 0, 0, 1, 0);

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_y", 32'(m_y), 0);
        chk("rst_carrier", 32'(m_car), 0);
        chk("rst_busy", 32'(m_busy), 0);
        chk("rst_ready", 32'(m_ready), 0);
        chk("rst_done", 32'(m_done), 0);
        rst = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            m_valid = tbl[i].v;
            m_data  = tbl[i].d;
            #1;
            chk($sformatf("row%0d_y", i), 32'(m_y), 32'(tbl[i].y));
            chk($sformatf("row%0d_carrier", i), 32'(m_car), 32'(tbl[i].car));
            chk($sformatf("row%0d_busy", i), 32'(m_busy), 32'(tbl[i].busy));
            chk($sformatf("row%0d_ready", i), 32'(m_ready), 32'(tbl[i].rdy));
            chk($sformatf("row%0d_done", i), 32'(m_done), 32'(tbl[i].done));
        end

        // asynchronous reset in the middle of a symbol
        @(negedge clk);
        m_valid = 1'b1;
        m_data  = 2'd3;
        @(negedge clk);
        m_valid = 1'b0;
        m_data  = 2'd0;
        #1;
        chk("mid_y_before", 32'(m_y), 15);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_y", 32'(m_y), 0);
        chk("arst_carrier", 32'(m_car), 0);
        chk("arst_busy", 32'(m_busy), 0);
        chk("arst_ready", 32'(m_ready), 0);
        chk("arst_done", 32'(m_done), 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rel_ready", 32'(m_ready), 1);
        chk("rel_y", 32'(m_y), 0);
        repeat (10) begin
            @(negedge clk);
            #1;
            chk("rel_no_done", 32'(m_done), 0);
            chk("rel_idle", 32'(m_busy), 0);
        end

        run_sym(0, 4, 2, 3'd1, 4'd1);
        run_sym(0, 4, 2, 3'd0, 4'd0);
        run_sym(1, 2, 1, 3'd3, 4'd9);
        run_sym(1, 2, 1, 3'd1, 4'd3);
        run_sym(2, 10, 3, 3'd5, 4'd10);
        run_sym(2, 10, 3, 3'd7, 4'd14);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ask_mod_stream.md
# ask_mod_stream

Parametrised M-ASK/OOK modulator for the modulation chain. It derives a square carrier from the system clock by integer division and accepts symbols over a valid/ready handshake. Each symbol is held for a fixed number of carrier periods, and the output is a registered amplitude word: symbol level while the carrier is high, 0 while it is low. Upstream framers feed it, and the DAC/IO stage consumes `y`.

## Interface
- `DIV`, default 4: carrier period in clk cycles; even, ≥ 2.
- `CYC_PER_SYM`, default 2: carrier periods per symbol; ≥ 1.
- `BITS`, default 1: bits per symbol (1 = OOK, 2 = 4-ASK, …).
- `STEP`, default 1: amplitude increment per symbol code.
- `AW`, default 1: output width; (2^BITS−1)·STEP must be < 2^AW.
- `clk`, input, 1: system clock, rising edge.
- `rst`, input, 1: reset, asynchronous, active-low.
- `s_valid`, input, 1: upstream symbol valid.
- `s_ready`, output, 1: block can accept a symbol this cycle.
- `s_data`, input, BITS: symbol code k.
- `y`, output, AW: modulated amplitude, registered.
- `carrier`, output, 1: registered carrier square wave.
- `busy`, output, 1: a symbol is being transmitted.
- `sym_done`, output, 1: one-cycle pulse in the final cycle of each symbol.

## Operation
- **State machine:** two states, IDLE and ACTIVE.
- **Counters:**
  - `cnt` runs 0..DIV−1 and sets the carrier phase.
  - `sym_cnt` runs 0..CYC_PER_SYM−1 and counts carrier periods.
  - Both counters wrap to 0.
- **Carrier:** `carrier` = 1 for `cnt` < DIV/2, 0 otherwise. The duty cycle is 50 %.
- **Amplitude:** `amp` = k·STEP, computed at AW width with no overflow, given the parameter constraint.
- **Output:** `y` = `amp` when `carrier` = 1, else 0.
- **Last cycle:** `last` = ACTIVE && `cnt` == DIV−1 && `sym_cnt` == CYC_PER_SYM−1.
- **Ready:** `s_ready` = `rst` && (IDLE || `last`). It is combinational.
- **Accept:** `s_valid` && `s_ready` at a clock edge.
  - Latches `s_data` into the symbol register.
  - Clears `cnt` and `sym_cnt` to 0.
  - Enters or stays in ACTIVE.
- **IDLE behaviour:**
  - Both counters are held at 0.
  - `y` = 0, `carrier` = 0, `busy` = 0.
  - `s_data` is ignored unless `s_valid` is asserted.
- **ACTIVE → IDLE:** happens in the `last` cycle when there is no accept.
- **ACTIVE → ACTIVE (back-to-back):** happens in the `last` cycle with an accept. The next symbol starts with no gap and the carrier phase stays continuous.
- **Mid-symbol input:** `s_valid` outside the `last` cycle is not accepted. Upstream must hold `s_data`/`s_valid` until ready.
- **Output pulses:** `sym_done` = `last`, and `busy` = ACTIVE.
- **Zero code:** k = 0 transmits a full-length symbol with `y` = 0. It is timed exactly like any other symbol, and `busy` = 1.

## Timing
- **Reset values:** `y` = 0, `carrier` = 0, `busy` = 0, `sym_done` = 0, `s_ready` = 0 while `rst` is low. State is IDLE and both counters are 0.
- **Reset mid-symbol:** takes effect immediately (asynchronous). The symbol is discarded and no `sym_done` is issued.
- **Latency:** with an accept at edge T, `y` = `amp` and `carrier` = 1 from edge T+1, i.e. the cycle after the accept.
- **Symbol length:** exactly DIV·CYC_PER_SYM cycles, measured from edge T+1.
- **First symbol after accept:** `y` follows the pattern `amp` for DIV/2 cycles, then 0 for DIV/2 cycles, repeated CYC_PER_SYM times.
- **Back-to-back timing:** the accept edge coincides with the end of the previous symbol, and the new symbol's first cycle follows directly. Throughput is 1 symbol per DIV·CYC_PER_SYM cycles.
- **Stall:** when there is no accept at `last`, `busy` and `y` fall at the next edge.

## Test plan
- **Reset check:** `rst` = 0 asynchronously mid-symbol (DIV=4, CYC_PER_SYM=2, BITS=2, STEP=5, AW=4) → `y`, `carrier`, `busy`, `s_ready` all 0 with no clock edge. After release, `s_ready` = 1 and `y` = 0.
- **Single symbol:** accept k=3 at edge T → `y` = 15,15,0,0,15,15,0,0 on cycles T+1..T+8. `sym_done` pulses at T+8, `busy` = 0 from T+9 (when there is no new valid).
- **Back-to-back:** `s_valid` held high, codes 1,2,0 → `y` = 5,5,0,0,5,5,0,0,10,10,0,0,10,10,0,0,0×8 with no gap. `s_ready` is high only in the `last` cycles, and `busy` stays 1 for 24 cycles.
- **Mid-symbol hold:** `s_valid` raised at cycle T+3 of a symbol → not accepted until the `last` cycle (T+8). The new symbol starts at T+9 and `s_data` is sampled only at T+8.
- **OOK defaults:** DIV=4, CYC_PER_SYM=2, BITS=1, STEP=1, AW=1. Bit 1 → `y` = 1,1,0,0,1,1,0,0; bit 0 → eight cycles of 0 with `busy` = 1.
- **Parameter sweep:** DIV=2, CYC_PER_SYM=1 and DIV=10, CYC_PER_SYM=3 → symbol length 2 and 30 cycles respectively. The carrier is high exactly DIV/2 cycles per period, and the scoreboard compares `y` against the reference model.
